// File: rtl/tg_uart_fifo.sv
// Host-side byte buffering for the serial controller: TX/RX FWFT FIFOs plus an io sequencer.
// Latency: TX push -> write strobe 2 cycles; rx_ready -> read strobe 1 cycle, byte visible 2 cycles.
// Backpressure: host sees full/empty/counts; full RX FIFO drops the byte and sets rx_overrun.

module tg_uart_fifo_buf #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic [AW:0]  cnt_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == FULL_CNT);
    assign do_pop     = pop_i && !empty_o;
    // A pop frees the slot in the same cycle, so a push on a full buffer still lands.
    assign do_push    = push_i && (!full_o || do_pop);
    assign drop_o     = push_i && !do_push;
    assign head_dat_o = mem_q[rptr_q];
    assign cnt_o      = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end
endmodule

module tg_uart_fifo #(
    parameter int TX_AW = 4,
    parameter int RX_AW = 4
) (
    input  logic             io_clk,
    input  logic             io_rst_n,
    input  logic [7:0]       host_wdata,
    input  logic             host_we,
    output logic             host_wfull,
    output logic [TX_AW:0]   host_tx_cnt,
    output logic [7:0]       host_rdata,
    input  logic             host_re,
    output logic             host_rempty,
    output logic [RX_AW:0]   host_rx_cnt,
    output logic             rx_overrun,
    input  logic             rx_ovr_clr,
    output logic [7:0]       uart_wdata,
    input  logic [7:0]       uart_rdata,
    output logic             uart_req,
    output logic             uart_wr,
    input  logic             uart_ack,
    input  logic             uart_tx_busy,
    input  logic             uart_rx_ready
);
    typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_WHI, T_WLO} tx_state_e;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_GAP} rx_state_e;

    tx_state_e  tx_q, tx_d;
    rx_state_e  rx_q, rx_d;
    logic       uart_req_q;
    logic       uart_wr_q;
    logic [7:0] uart_wdata_q;
    logic       rx_ovr_q;

    logic       tx_start;
    logic       rx_start;
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       tx_drop;
    logic       rx_full;
    logic       rx_drop;
    logic       unused_sigs;

    assign unused_sigs = ^{uart_ack, tx_drop, rx_full};

    tg_uart_fifo_buf #(.AW(TX_AW), .W(8)) u_tx_fifo (
        .clk        (io_clk),
        .rst_n      (io_rst_n),
        .push_i     (host_we),
        .push_dat_i (host_wdata),
        .pop_i      (tx_start),
        .head_dat_o (tx_head),
        .cnt_o      (host_tx_cnt),
        .full_o     (host_wfull),
        .empty_o    (tx_empty),
        .drop_o     (tx_drop)
    );

    tg_uart_fifo_buf #(.AW(RX_AW), .W(8)) u_rx_fifo (
        .clk        (io_clk),
        .rst_n      (io_rst_n),
        .push_i     (rx_q == R_READ),
        .push_dat_i (uart_rdata),
        .pop_i      (host_re),
        .head_dat_o (host_rdata),
        .cnt_o      (host_rx_cnt),
        .full_o     (rx_full),
        .empty_o    (host_rempty),
        .drop_o     (rx_drop)
    );

    // RX wins: TX may not start while a read strobe is active or about to begin.
    always_comb begin
        rx_start = (rx_q == R_IDLE) && uart_rx_ready;
        tx_start = (tx_q == T_IDLE) && !tx_empty && !uart_tx_busy &&
                   (rx_q != R_READ) && !rx_start;

        rx_d = rx_q;
        case (rx_q)
            R_IDLE:  if (rx_start) rx_d = R_READ;
            R_READ:  rx_d = R_GAP;
            default: rx_d = R_IDLE;
        endcase

        tx_d = tx_q;
        case (tx_q)
            T_IDLE:  if (tx_start) tx_d = T_ISSUE;
            T_ISSUE: tx_d = T_WHI;
            T_WHI:   if (uart_tx_busy) tx_d = T_WLO;
            default: if (!uart_tx_busy) tx_d = T_IDLE;
        endcase
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            tx_q         <= T_IDLE;
            rx_q         <= R_IDLE;
            uart_req_q   <= 1'b0;
            uart_wr_q    <= 1'b0;
            uart_wdata_q <= '0;
            rx_ovr_q     <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            uart_req_q <= (tx_d == T_ISSUE) || (rx_d == R_READ);
            uart_wr_q  <= (tx_d == T_ISSUE);
            if (tx_start) begin
                uart_wdata_q <= tx_head;
            end
            if (rx_drop) begin
                rx_ovr_q <= 1'b1;
            end else if (rx_ovr_clr) begin
                rx_ovr_q <= 1'b0;
            end
        end
    end

    assign uart_req   = uart_req_q;
    assign uart_wr    = uart_wr_q;
    assign uart_wdata = uart_wdata_q;
    assign rx_overrun = rx_ovr_q;
endmodule

// File: tb/tb_tg_uart_fifo.sv
// Bench for tg_uart_fifo: controller model, queue-based reference model and negedge monitor.
module tb_tg_uart_fifo;
    logic       io_clk = 1'b0;
    logic       io_rst_n;
    logic [7:0] host_wdata;
    logic       host_we;
    logic       host_wfull;
    logic [4:0] host_tx_cnt;
    logic [7:0] host_rdata;
    logic       host_re;
    logic       host_rempty;
    logic [4:0] host_rx_cnt;
    logic       rx_overrun;
    logic       rx_ovr_clr;
    logic [7:0] uart_wdata;
    logic [7:0] uart_rdata;
    logic       uart_req;
    logic       uart_wr;
    logic       uart_ack;
    logic       uart_tx_busy;
    logic       uart_rx_ready;
    logic       busy_ctrl;
    logic       busy_force;

    assign uart_tx_busy = busy_ctrl | busy_force;

    tg_uart_fifo #(.TX_AW(4), .RX_AW(4)) dut (
        .io_clk        (io_clk),
        .io_rst_n      (io_rst_n),
        .host_wdata    (host_wdata),
        .host_we       (host_we),
        .host_wfull    (host_wfull),
        .host_tx_cnt   (host_tx_cnt),
        .host_rdata    (host_rdata),
        .host_re       (host_re),
        .host_rempty   (host_rempty),
        .host_rx_cnt   (host_rx_cnt),
        .rx_overrun    (rx_overrun),
        .rx_ovr_clr    (rx_ovr_clr),
        .uart_wdata    (uart_wdata),
        .uart_rdata    (uart_rdata),
        .uart_req      (uart_req),
        .uart_wr       (uart_wr),
        .uart_ack      (uart_ack),
        .uart_tx_busy  (uart_tx_busy),
        .uart_rx_ready (uart_rx_ready)
    );

    always #5 io_clk = ~io_clk;

    int cyc = 0;
    int checks = 0;
    int passed = 0;
    always @(posedge io_clk) cyc <= cyc + 1;
    always @(posedge io_clk) uart_ack <= uart_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: expected TX byte order and the RX FIFO contents.
    logic [7:0] tx_exp[$];
    logic [7:0] rx_model[$];
    logic       exp_ovr;
    int         wr_cnt = 0, rd_cnt = 0, last_wr_cyc = 0, last_rd_cyc = 0;
    logic       prev_wr, wr_seen, busy_hi_seen, busy_lo_seen;

    always @(negedge io_clk) begin : monitor
        logic pop_now, ovr_set;
        if (!io_rst_n) begin
            tx_exp.delete();
            rx_model.delete();
            exp_ovr = 0; prev_wr = 0; wr_seen = 0;
            busy_hi_seen = 0; busy_lo_seen = 0;
        end else begin
            check("rx_cnt", host_rx_cnt, rx_model.size());
            check("rempty", host_rempty, rx_model.size() == 0);
            check("overrun", rx_overrun, exp_ovr);
            if (rx_model.size() > 0) check("rx_head", host_rdata, rx_model[0]);

            if (uart_req && uart_wr) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                check("wr_single_cycle", prev_wr, 1'b0);
                if (wr_seen) check("busy_period_between_writes", busy_hi_seen && busy_lo_seen, 1'b1);
                wr_seen = 1; busy_hi_seen = 0; busy_lo_seen = 0;
                if (tx_exp.size() == 0) begin
                    checks++;
                    $display("FAIL tx_unexpected: write strobe data %0h with nothing queued (cycle %0d)", uart_wdata, cyc);
                end else begin
                    check("tx_data", uart_wdata, tx_exp.pop_front());
                end
            end
            prev_wr = uart_req && uart_wr;
            if (uart_tx_busy) busy_hi_seen = 1;
            else if (busy_hi_seen) busy_lo_seen = 1;

            pop_now = host_re && (rx_model.size() > 0);
            ovr_set = 0;
            if (pop_now) void'(rx_model.pop_front());
            if (uart_req && !uart_wr) begin
                rd_cnt++;
                last_rd_cyc = cyc;
                if (rx_model.size() < 16) rx_model.push_back(uart_rdata);
                else ovr_set = 1;
            end
            if (ovr_set) exp_ovr = 1;
            else if (rx_ovr_clr) exp_ovr = 0;
        end
    end

    // Controller model: some cycles after each write strobe, pulse busy.
    int d1, d2;
    initial begin
        busy_ctrl = 0;
        forever begin
            @(negedge io_clk);
            if (io_rst_n && uart_req && uart_wr) begin
                d1 = $urandom_range(1, 3);
                d2 = $urandom_range(2, 5);
                repeat (d1) @(posedge io_clk);
                #1 busy_ctrl = 1;
                repeat (d2) @(posedge io_clk);
                #1 busy_ctrl = 0;
            end
        end
    end

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] b);
        host_wdata = b;
        host_we    = 1;
        if (!host_wfull) tx_exp.push_back(b);
        tick();
        host_we = 0;
    endtask

    task automatic pop_rx();
        host_re = 1;
        tick();
        host_re = 0;
    endtask

    task automatic deliver_rx(input logic [7:0] b, input bit pop_in_read, input bit clr_in_read);
        int start = rd_cnt;
        int m = cyc;
        uart_rdata    = b;
        uart_rx_ready = 1;
        tick();
        host_re    = pop_in_read;
        rx_ovr_clr = clr_in_read;
        tick();
        host_re    = 0;
        rx_ovr_clr = 0;
        for (int i = 0; i < 20 && rd_cnt == start; i++) tick();
        tick();
        uart_rx_ready = 0;
        tick();
        tick();
        check("rd_strobes_per_byte", rd_cnt - start, 1);
        check("rd_latency", last_rd_cyc - m, 1);
    endtask

    task automatic drain_tx();
        int t = 0;
        while (tx_exp.size() != 0 && t < 400) begin
            tick();
            t++;
        end
        check("tx_drain_timeout", tx_exp.size(), 0);
        repeat (12) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wfull"}, host_wfull, 1'b0);
        check({tag, "_rempty"}, host_rempty, 1'b1);
        check({tag, "_tx_cnt"}, host_tx_cnt, 5'd0);
        check({tag, "_rx_cnt"}, host_rx_cnt, 5'd0);
        check({tag, "_req"}, uart_req, 1'b0);
        check({tag, "_wr"}, uart_wr, 1'b0);
        check({tag, "_wdata"}, uart_wdata, 8'h00);
        check({tag, "_overrun"}, rx_overrun, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w, r;
        io_rst_n = 0; host_wdata = 0; host_we = 0; host_re = 0; rx_ovr_clr = 0;
        uart_rdata = 0; uart_rx_ready = 0; busy_force = 0;
        tick(); tick();
        check_reset_outputs("por");
        io_rst_n = 1;
        tick(); tick();

        // Single byte latency.
        n = cyc;
        w = wr_cnt;
        push_tx(8'h55);
        for (int i = 0; i < 20 && wr_cnt == w; i++) tick();
        check("tx_latency", last_wr_cyc - n, 2);
        drain_tx();
        check("tx_cnt_after_55", host_tx_cnt, 5'd0);

        // Back-to-back bytes.
        w = wr_cnt;
        push_tx(8'h41); push_tx(8'h42); push_tx(8'h43);
        drain_tx();
        check("b2b_strobes", wr_cnt - w, 3);

        // Reset while waiting for busy to rise.
        w = wr_cnt;
        push_tx(8'h11); push_tx(8'h22);
        for (int i = 0; i < 20 && wr_cnt == w; i++) tick();
        io_rst_n = 0;
        #1;
        check_reset_outputs("midwhi");
        tick(); tick();
        io_rst_n = 1;
        w = wr_cnt;
        repeat (30) tick();
        check("no_req_after_reset", wr_cnt - w, 0);

        // Single RX byte.
        deliver_rx(8'hA5, 0, 0);
        check("rx_a5_data", host_rdata, 8'hA5);
        check("rx_a5_cnt", host_rx_cnt, 5'd1);
        pop_rx();

        // Fill RX past capacity.
        for (int i = 0; i < 17; i++) deliver_rx(8'h10 + 8'(i), 0, 0);
        check("ovr_cnt", host_rx_cnt, 5'd16);
        check("ovr_flag", rx_overrun, 1'b1);
        check("ovr_head", host_rdata, 8'h10);
        deliver_rx(8'hEE, 0, 1);
        check("ovr_set_wins", rx_overrun, 1'b1);
        rx_ovr_clr = 1;
        tick();
        rx_ovr_clr = 0;
        tick();
        check("ovr_cleared", rx_overrun, 1'b0);
        deliver_rx(8'hC7, 1, 0);
        check("full_pushpop_cnt", host_rx_cnt, 5'd16);
        check("full_pushpop_head", host_rdata, 8'h11);
        check("full_pushpop_no_ovr", rx_overrun, 1'b0);
        repeat (16) pop_rx();
        check("rx_drained", host_rempty, 1'b1);

        // Read and write become eligible in the same cycle.
        w = wr_cnt;
        r = rd_cnt;
        host_wdata = 8'h77; host_we = 1; tx_exp.push_back(8'h77);
        tick();
        host_we = 0;
        n = cyc;
        uart_rdata = 8'h3C; uart_rx_ready = 1;
        for (int i = 0; i < 20 && rd_cnt == r; i++) tick();
        tick();
        uart_rx_ready = 0;
        for (int i = 0; i < 20 && wr_cnt == w; i++) tick();
        check("arb_read_cycle", last_rd_cyc - n, 1);
        check("arb_write_after_read", last_wr_cyc > last_rd_cyc, 1'b1);
        check("arb_single_read", rd_cnt - r, 1);
        drain_tx();
        pop_rx();

        // Fill TX while the controller holds busy.
        busy_force = 1;
        for (int i = 0; i < 17; i++) push_tx(8'h80 + 8'(i));
        check("tx_full_cnt", host_tx_cnt, 5'd16);
        check("tx_full_flag", host_wfull, 1'b1);
        w = wr_cnt;
        busy_force = 0;
        drain_tx();
        check("tx_full_strobes", wr_cnt - w, 16);
        check("tx_full_drained", host_tx_cnt, 5'd0);

        // Random traffic.
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: if (tx_exp.size() < 10) push_tx(8'($urandom));
                4, 5: deliver_rx(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
                6, 7: pop_rx();
                default: tick();
            endcase
        end
        drain_tx();
        check("final_tx_cnt", host_tx_cnt, 5'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tg_uart_fifo.md
Name: tg_uart_fifo

Overview:
- Byte-buffering bridge that sits directly upstream of the serial controller's io port (io_wdata/io_rdata/io_req/io_wr/io_ack, uart_tx_busy, uart_rx_ready).
- Host logic pushes TX bytes and pops RX bytes through two independent FWFT FIFOs.
- An io-side sequencer drains the TX FIFO into the controller and moves received bytes into the RX FIFO, so the host never polls busy/ready.

Parameters:
- TX_AW, 4, log2 of TX FIFO depth (16 entries)
- RX_AW, 4, log2 of RX FIFO depth (16 entries)

Ports:
- io_clk  in  1  clock
- io_rst_n  in  1  asynchronous active-low reset
- host_wdata  in  8  TX byte to enqueue
- host_we  in  1  TX push strobe
- host_wfull  out  1  TX FIFO full
- host_tx_cnt  out  TX_AW+1  TX FIFO occupancy
- host_rdata  out  8  RX FIFO head byte (FWFT)
- host_re  in  1  RX pop strobe
- host_rempty  out  1  RX FIFO empty
- host_rx_cnt  out  RX_AW+1  RX FIFO occupancy
- rx_overrun  out  1  sticky: byte dropped, RX FIFO full
- rx_ovr_clr  in  1  clears rx_overrun
- uart_wdata  out  8  to controller io_wdata
- uart_rdata  in  8  from controller io_rdata
- uart_req  out  1  to controller io_req
- uart_wr  out  1  to controller io_wr
- uart_ack  in  1  from controller io_ack; monitored only, sequencing does not depend on it
- uart_tx_busy  in  1  controller send busy
- uart_rx_ready  in  1  controller receive data ready

Behaviour:
- One clock domain, io_clk.
- Reset is asynchronous, active-low: io_rst_n low clears both FIFO pointers and counts, both FSMs (to idle), and rx_overrun.
  - Reset output values: host_wfull=0, host_rempty=1, counts=0, uart_req=0, uart_wr=0, uart_wdata=0, rx_overrun=0.
  - host_rdata while empty is don't-care.
  - Reset mid-transfer aborts it; the bytes involved are lost.
- FIFOs: circular buffers with pointer width AW and count width AW+1; pointers wrap modulo depth.
  - Push when full is ignored; count is unchanged.
  - Pop when empty is ignored.
  - Simultaneous push and pop: both take effect and count is unchanged.
  - Pop on empty with simultaneous push: the push only takes effect.
  - host_rdata is the head entry, combinational from RAM and read pointer.
- uart_req, uart_wr and uart_wdata are registered Moore outputs decoded from the FSM states.
- TX FSM states: T_IDLE, T_ISSUE, T_WHI, T_WLO.
  - T_IDLE -> T_ISSUE when tx_cnt != 0, uart_tx_busy = 0, and RX FSM is neither in R_READ nor entering it.
  - On the T_IDLE -> T_ISSUE transition, load uart_wdata from the TX head and pop the TX FIFO.
  - T_ISSUE lasts exactly 1 cycle with uart_req=1, uart_wr=1, then goes to T_WHI.
  - T_WHI waits for uart_tx_busy=1, then goes to T_WLO.
  - T_WLO waits for uart_tx_busy=0, then goes to T_IDLE.
- RX FSM states: R_IDLE, R_READ, R_GAP.
  - R_IDLE -> R_READ when uart_rx_ready=1.
  - R_READ lasts exactly 1 cycle with uart_req=1, uart_wr=0; uart_rdata is pushed into the RX FIFO at the end of that cycle.
  - R_READ -> R_GAP, which lasts 1 cycle and ignores uart_rx_ready while the controller's ready flag clears. R_GAP -> R_IDLE.
- Arbitration: RX has priority. At most one of T_ISSUE / R_READ is active in any cycle; never drive uart_req with both.
- Overrun: if the RX FIFO is full in R_READ, the read is still performed, the byte is discarded and rx_overrun is set.
  - rx_ovr_clr clears rx_overrun.
  - Set and clear in the same cycle: set wins.
- Latency:
  - host_we into an empty TX FIFO at cycle N (idle, not busy) -> uart_req=uart_wr=1 during cycle N+2.
  - uart_rx_ready first high at cycle M (R_IDLE) -> read strobe in M+1 -> host_rempty=0 in M+2.
- Back-to-back TX: next issue occurs at the earliest the cycle after uart_tx_busy is seen low in T_WLO.

Test Plan:
- Reset with io_rst_n=0 mid-T_WHI -> all outputs at their reset values, host_rempty=1, host_tx_cnt=0; no uart_req after release until a new push.
- Push 0x55 at cycle N with controller idle -> uart_req=1, uart_wr=1, uart_wdata=0x55 in N+2 for exactly 1 cycle; host_tx_cnt returns to 0.
- Push 0x41,0x42,0x43 back-to-back -> three single-cycle write strobes in order; each strobe is separated by a full uart_tx_busy high/low period.
- Model uart_rx_ready rising with uart_rdata=0xA5 -> one read strobe (uart_req=1, uart_wr=0), no second strobe during R_GAP, host_rdata=0xA5, host_rx_cnt=1.
- Deliver 17 bytes into the 16-deep RX FIFO without popping -> host_rx_cnt=16, rx_overrun=1, and head is still byte 1. Then pulse rx_ovr_clr -> rx_overrun=0.
- uart_rx_ready rises in the same cycle a TX push becomes eligible -> R_READ first, T_ISSUE one or more cycles later; uart_req never shows a write and a read strobe in the same cycle. Also push and pop simultaneously on a full RX FIFO -> count unchanged.
